// File: rtl/mmio_bus.sv
// Data-side memory bus: routes MEM-stage accesses to the external synchronous RAM or to
// on-chip peripherals (UART transmitter with TX FIFO, free-running timer) at uniform 1-cycle read latency.
module mmio_bus #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [31:0] ADDR_UART_TX     = 32'h1000_0000;
  localparam logic [31:0] ADDR_UART_STATUS = 32'h1000_0004;
  localparam logic [31:0] ADDR_TIMER       = 32'h1000_0008;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_MMIO
  } rd_sel_e;

  // Address decode
  logic ram_hit, tx_hit, stat_hit, tmr_hit;

  assign ram_hit  = (mem_addr[31:28] == 4'h0);
  assign tx_hit   = (mem_addr == ADDR_UART_TX);
  assign stat_hit = (mem_addr == ADDR_UART_STATUS);
  assign tmr_hit  = (mem_addr == ADDR_TIMER);

  assign ram_we    = mem_rw & ram_hit & ~rst;
  assign ram_addr  = mem_addr;
  assign ram_wdata = mem_wdata;

  // Registers
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [31:0]   timer_q, timer_d;
  rd_sel_e       sel_q, sel_d;
  logic [31:0]   rdata_q, rdata_d;

  logic fifo_empty, fifo_full, pop, push_req, push_ok, busy;
  logic [3:0] status;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign busy       = (state_q != ST_IDLE);
  assign status     = {ovf_q, busy, fifo_full, fifo_empty};

  // UART transmitter FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q[AW-1:0]];
          cnt_d   = CNT_MAX;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_MAX;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q[AW-1:0]];
            cnt_d   = CNT_MAX;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, overflow flag, timer and read path
  always_comb begin
    push_req = mem_rw & tx_hit;
    push_ok  = push_req & (~fifo_full | pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    ovf_d = ovf_q;
    if (mem_rw && stat_hit) begin
      ovf_d = 1'b0;
    end else if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end

    timer_d = (mem_rw && tmr_hit) ? mem_wdata : timer_q + 32'd1;

    // A timer read returns the value the timer takes at this edge, so a read right after a load sees load+1.
    sel_d   = SEL_NONE;
    rdata_d = 32'd0;
    if (!mem_rw) begin
      if (ram_hit) begin
        sel_d = SEL_RAM;
      end else begin
        sel_d = SEL_MMIO;
        if (stat_hit) begin
          rdata_d = {28'd0, status};
        end else if (tmr_hit) begin
          rdata_d = timer_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      timer_q   <= 32'd0;
      sel_q     <= SEL_NONE;
      rdata_q   <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= mem_wdata[7:0];
    end
  end

  assign mem_rdata = (sel_q == SEL_RAM) ? ram_rdata : rdata_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Bench for mmio_bus: directed scenarios plus randomized traffic, each cycle compared
// against a transaction-level model (byte queue, expected line waveform, timer value, RAM shadow).
module tb_mmio_bus;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  localparam logic [31:0] TXA  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;
  localparam logic [31:0] TMR  = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rw = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        uart_tx;

  // Clock / reset
  always #5 clk = ~clk;

  mmio_bus #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .uart_tx  (uart_tx)
  );

  // External synchronous RAM
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr[9:2]];
  end

  // Scoreboard / reference model state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  byte_q [$];
  logic        line_q [$];
  logic [31:0] exp_q  [$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_timer = 32'd0;
  logic [31:0] exp_ram [256];
  logic        chk_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic exp_tx();
    return (line_q.size() != 0) ? line_q[0] : 1'b1;
  endfunction

  // Advance the model across one clock edge for the access presented this cycle.
  task automatic model_edge(input logic rw, input logic [31:0] a, input logic [31:0] wd, input logic r);
    logic [3:0] st;
    logic [7:0] b;
    chk_rdata = 1'b0;
    exp_q.delete();
    if (r) begin
      byte_q.delete();
      line_q.delete();
      m_ovf   = 1'b0;
      m_timer = 32'd0;
      exp_q.push_back(32'd0);
      chk_rdata = 1'b1;
      return;
    end
    st = {m_ovf, line_q.size() != 0, byte_q.size() == DEPTH, byte_q.size() == 0};
    if (!rw) begin
      chk_rdata = 1'b1;
      if (a[31:28] == 4'h0)  exp_q.push_back(exp_ram[a[9:2]]);
      else if (a == STAT)    exp_q.push_back({28'd0, st});
      else if (a == TMR)     exp_q.push_back(m_timer + 32'd1);
      else                   exp_q.push_back(32'd0);
    end else if (a[31:28] == 4'h0) begin
      exp_ram[a[9:2]] = wd;
    end
    m_timer = (rw && a == TMR) ? wd : m_timer + 32'd1;
    if (line_q.size() != 0) line_q.delete(0);
    if (line_q.size() == 0 && byte_q.size() != 0) begin
      b = byte_q.pop_front();
      repeat (CPB) line_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) line_q.push_back(b[i]);
      repeat (CPB) line_q.push_back(1'b1);
    end
    if (rw && a == TXA) begin
      if (byte_q.size() < DEPTH) byte_q.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (rw && a == STAT) m_ovf = 1'b0;
  endtask

  // Driver: one access per cycle, starting and ending on a falling edge.
  task automatic cyc(input logic rw, input logic [31:0] a, input logic [31:0] wd, input logic r);
    mem_rw    = rw;
    mem_addr  = a;
    mem_wdata = wd;
    rst       = r;
    #1;
    check("ram_we", {31'd0, ram_we}, {31'd0, rw & (a[31:28] == 4'h0) & ~r});
    if (a[31:28] == 4'h0) begin
      check("ram_addr", ram_addr, a);
      if (rw) check("ram_wdata", ram_wdata, wd);
    end
    model_edge(rw, a, wd, r);
    @(negedge clk);
    if (chk_rdata) check("mem_rdata", mem_rdata, exp_q[0]);
    check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, a, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0);
  endtask

  initial begin
    logic [31:0] other [4];
    int          op;
    other[0] = 32'h1000_000C;
    other[1] = 32'h2000_0000;
    other[2] = 32'hFFFF_FFFC;
    other[3] = 32'h1000_0010;

    @(negedge clk);
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
    check("reset_rdata", mem_rdata, 32'd0);
    rd(STAT);
    check("reset_status", mem_rdata, 32'h1);

    // Fill every RAM word through the bus so later reads have known contents.
    for (int i = 0; i < 256; i++) wr(32'(i * 4), $urandom);

    wr(32'h0000_0040, 32'h1234_5678);
    rd(32'h0000_0040);
    check("ram_read_40", mem_rdata, 32'h1234_5678);

    wr(TMR, 32'hFFFF_FFFE);
    rd(TMR); check("timer_ffff", mem_rdata, 32'hFFFF_FFFF);
    rd(TMR); check("timer_wrap", mem_rdata, 32'h0);
    rd(TMR); check("timer_one", mem_rdata, 32'h1);

    rd(32'h2000_0000);
    check("unmapped_read", mem_rdata, 32'h0);
    wr(32'h2000_0000, 32'hDEAD_BEEF);
    rd(STAT);
    check("unmapped_no_effect", mem_rdata, 32'h1);

    // Single 0x55 frame, line checked cycle by cycle against the model.
    wr(TXA, 32'h55);
    repeat (45) rd(STAT);
    check("frame_done_status", mem_rdata, 32'h1);

    // Overflow while a frame is in flight, then back-to-back drain.
    wr(TXA, 32'hA5);
    rd(STAT);
    for (int i = 0; i < 9; i++) wr(TXA, 32'($urandom_range(0, 255)));
    rd(STAT);
    check("ovf_full_status", mem_rdata, 32'hE);
    wr(STAT, 32'd0);
    rd(STAT);
    check("ovf_cleared_status", mem_rdata, 32'h6);
    repeat (9 * 10 * CPB + 10) rd(STAT);
    check("drained_status", mem_rdata, 32'h1);

    // Reset in the middle of the data bits.
    wr(TXA, 32'h3C);
    repeat (12) rd(STAT);
    cyc(1'b0, STAT, 32'd0, 1'b1);
    check("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
    rd(STAT);
    check("rst_mid_status", mem_rdata, 32'h1);
    rd(TMR);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 99);
      if ($urandom_range(0, 399) == 0)  cyc(1'b0, STAT, 32'd0, 1'b1);
      else if (op < 20) wr(32'($urandom_range(0, 255) * 4), $urandom);
      else if (op < 40) rd(32'($urandom_range(0, 255) * 4));
      else if (op < 46) wr(TXA, $urandom);
      else if (op < 62) rd(STAT);
      else if (op < 65) wr(STAT, $urandom);
      else if (op < 75) rd(TMR);
      else if (op < 78) wr(TMR, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      else if (op < 80) wr(TMR, $urandom);
      else if (op < 88) rd(other[$urandom_range(0, 3)]);
      else if (op < 92) wr(other[$urandom_range(0, 3)], $urandom);
      else              rd(32'h0FFF_FC00 + 32'($urandom_range(0, 255) * 4));
    end
    repeat (10 * CPB * (DEPTH + 2)) rd(STAT);
    check("final_status", mem_rdata, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
